// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the number-guessing game.
// Holds the draw FSM state type, BCD and LFSR widths, and the LFSR step.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } rng_state_t;

  localparam int DIGIT_W = 4;
  localparam int LFSR_W  = 16;

  // Right-shift Fibonacci form: taps 16,14,13,11 sit at bits 0,2,3,5
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

  localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_BASE = 4'd10;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] q
  );
    return {^(q & LFSR_TAPS), q[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/target_rng_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR.
// Shifts on every clock; reset loads SEED.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED;
    end else begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/target_rng.sv
// target_rng: draws a random 1-3 digit BCD target at the start of each round.
// Build option TARGET_NO_REPEAT_EN: avoid repeating the previous target.
module target_rng
  import game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
  parameter int                MAX_RETRY = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_round,
  input  logic [1:0]         max_digits,
  output logic [DIGIT_W-1:0] target_digit_1,
  output logic [DIGIT_W-1:0] target_digit_2,
  output logic [DIGIT_W-1:0] target_digit_3,
  output logic               target_valid,
  output logic               busy
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  if (LFSR_SEED == '0) begin : g_seed_chk
    $error("target_rng: LFSR_SEED must be nonzero");
  end

  logic [LFSR_W-1:0]    lfsr;
  logic                 unused_lfsr;
  rng_state_t           state;
  logic [1:0]           n_dig;
  logic [1:0]           idx;
  logic [RW-1:0]        retry;
  logic [3*DIGIT_W-1:0] tgt;
  logic [3*DIGIT_W-1:0] next_t;
  logic [DIGIT_W-1:0]   nib;
  logic [DIGIT_W-1:0]   dval;
  logic                 take;
  logic                 last;
  logic                 req;
  logic                 rep;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign unused_lfsr = ^lfsr[LFSR_W-1:DIGIT_W];

  assign target_digit_1 = tgt[DIGIT_W-1:0];
  assign target_digit_2 = tgt[2*DIGIT_W-1:DIGIT_W];
  assign target_digit_3 = tgt[3*DIGIT_W-1:2*DIGIT_W];

  assign req = new_round && (state != DRAW);

  // Out-of-range nibbles are retried; the last retry folds them into 0-5
  always_comb begin
    nib    = lfsr[DIGIT_W-1:0];
    take   = (nib <= BCD_MAX) || (retry == RMAX);
    dval   = (nib <= BCD_MAX) ? nib : nib - BCD_BASE;
    next_t = tgt;
    unique case (1'b1)
      (idx == 2'd1): next_t[DIGIT_W-1:0]           = dval;
      (idx == 2'd2): next_t[2*DIGIT_W-1:DIGIT_W]   = dval;
      default:       next_t[3*DIGIT_W-1:2*DIGIT_W] = dval;
    endcase
    last = take && (idx == n_dig);
  end

`ifdef TARGET_NO_REPEAT_EN
  logic [3*DIGIT_W-1:0] prev_t;
  logic [3*DIGIT_W-1:0] mask;
  logic [1:0]           redraws;

  always_comb begin
    unique case (1'b1)
      (n_dig == 2'd1): mask = 12'h00F;
      (n_dig == 2'd2): mask = 12'h0FF;
      default:         mask = 12'hFFF;
    endcase
    rep = (((next_t ^ prev_t) & mask) == '0) && (redraws != 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_t  <= '0;
      redraws <= '0;
    end else if (req) begin
      redraws <= '0;
    end else if (state == DRAW && last) begin
      if (rep) begin
        redraws <= redraws + 2'd1;
      end else begin
        prev_t <= next_t;
      end
    end
  end
`else
  assign rep = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tgt          <= '0;
      target_valid <= 1'b0;
      busy         <= 1'b0;
      n_dig        <= 2'd1;
      idx          <= 2'd1;
      retry        <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (new_round) begin
            n_dig        <= (max_digits == 2'd0) ? 2'd1 : max_digits;
            tgt          <= '0;
            target_valid <= 1'b0;
            busy         <= 1'b1;
            idx          <= 2'd1;
            retry        <= '0;
            state        <= DRAW;
          end
        end
        DRAW: begin
          if (!take) begin
            retry <= retry + 1'b1;
          end else if (last && rep) begin
            tgt   <= '0;
            idx   <= 2'd1;
            retry <= '0;
          end else if (last) begin
            tgt          <= next_t;
            target_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= DONE;
          end else begin
            tgt   <= next_t;
            idx   <= idx + 2'd1;
            retry <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_target_rng.sv
// tb_target_rng: randomized scoreboard bench for target_rng.
// Expected targets come from an arithmetic LFSR model run ahead of the DUT.
`timescale 1ns/1ps
module tb_target_rng;
  import game_pkg::*;

  localparam logic [15:0] SEED = 16'hFFFF;
  localparam int          MAXR = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_round = 1'b0;
  logic [1:0] max_digits = 2'd0;
  logic [3:0] d1, d2, d3;
  logic       target_valid, busy;
  logic [11:0] tgt;

  assign tgt = {d3, d2, d1};

  always #5 clk = ~clk;

  target_rng #(
    .LFSR_SEED (SEED),
    .MAX_RETRY (MAXR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .new_round      (new_round),
    .max_digits     (max_digits),
    .target_digit_1 (d1),
    .target_digit_2 (d2),
    .target_digit_3 (d3),
    .target_valid   (target_valid),
    .busy           (busy)
  );

  typedef struct {
    logic [11:0] t;
    int          lat;
    int          req;
    int          n;
    bit          exh;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] m;
  logic [11:0] prev_model = '0;

  function automatic logic [15:0] step(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return (s >> 1) | ({15'd0, b} << 15);
  endfunction

  function automatic logic [11:0] dmask(input int n);
    return (n == 1) ? 12'h00F : (n == 2) ? 12'h0FF : 12'hFFF;
  endfunction

  // Walk the nibble stream exactly as the draw rules describe
  function automatic exp_t predict(input logic [15:0] start, input int n,
                                   input logic [11:0] prev);
    exp_t        e;
    logic [15:0] s;
    logic [3:0]  v;
    int          r;
    int          redo;
    bit          same;
    s = start;
    e.lat = 0;
    e.n = n;
    e.req = 0;
    redo = 0;
    forever begin
      e.t = '0;
      for (int d = 0; d < n; d++) begin
        r = 0;
        forever begin
          v = s[3:0];
          s = step(s);
          e.lat++;
          if (v < 4'd10) begin
            e.t[4*d +: 4] = v;
            break;
          end
          if (r == MAXR) begin
            e.t[4*d +: 4] = v - 4'd10;
            break;
          end
          r++;
        end
      end
      same = (e.t & dmask(n)) == (prev & dmask(n));
`ifdef TARGET_NO_REPEAT_EN
      if (same && redo < 2) begin
        redo++;
        continue;
      end
`endif
      break;
    end
    e.exh = same && (redo == 2);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp_v, cyc);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m <= SEED;
    else     m <= step(m);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop and compare when target_valid rises
  logic        pv = 1'b0;
  logic [11:0] last_t = '0;
  always @(posedge clk) begin
    exp_t f;
    #1;
    if (!rst) begin
      if (target_valid && !pv) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 32'(target_valid), 32'd0);
        end else begin
          f = q.pop_front();
          chk("target", 32'(tgt), 32'(f.t));
          chk("latency", 32'(cyc - f.req), 32'(f.lat));
          chk("busy_done", 32'(busy), 32'd0);
        end
        last_t = tgt;
      end else if (target_valid) begin
        chk("stable", 32'(tgt), 32'(last_t));
      end else if (q.size() > 0) begin
        chk("draw_flags", 32'({busy, target_valid}), 32'b10);
        chk("upper_zero", 32'(tgt & ~dmask(q[0].n)), 32'd0);
      end
    end
    pv = target_valid;
  end

  task automatic do_round(input int md, input int pulse_at, input bit chg,
                          output int obs_lat, output exp_t eo);
    int n;
    n = (md == 0) ? 1 : md;
    @(negedge clk);
    eo = predict(step(m), n, prev_model);
    eo.req = cyc + 1;
    q.push_back(eo);
    max_digits = 2'(md);
    new_round = 1'b1;
    @(negedge clk);
    new_round = 1'b0;
    if (chg) max_digits = 2'($urandom_range(0, 3));
    obs_lat = -1;
    for (int i = 1; i <= 120; i++) begin
      if (q.size() == 0) begin
        obs_lat = i - 1;
        break;
      end
      if (i == pulse_at && i < eo.lat) new_round = 1'b1;
      @(negedge clk);
      new_round = 1'b0;
    end
    if (obs_lat < 0) begin
      checks++;
      errors++;
      $display("FAIL round_timeout: no target_valid within 120 cycles");
      q.delete();
    end
    prev_model = eo.t;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    exp_t        eo;
    logic [11:0] last_obs;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("idle_digits", 32'(tgt), 32'd0);
    chk("idle_flags", 32'({target_valid, busy}), 32'd0);
    chk("idle_lfsr_live", 32'((dut.lfsr != 16'd0) && (dut.lfsr != SEED)), 32'd1);
    chk("idle_lfsr_model", 32'(dut.lfsr), 32'(m));

    do_round(1, 0, 1'b0, lat, eo);
    chk("round_lat", 32'(lat), 32'(eo.lat));
    do_round(0, 0, 1'b0, lat, eo);
    chk("round_lat", 32'(lat), 32'(eo.lat));
    do_round(3, 2, 1'b1, lat, eo);
    chk("round_lat", 32'(lat), 32'(eo.lat));

    for (int r = 0; r < 30; r++) begin
      do_round($urandom_range(0, 3), $urandom_range(0, 1) ? 2 : 0,
               1'($urandom_range(0, 1)), lat, eo);
      chk("round_lat", 32'(lat), 32'(eo.lat));
    end

    // Reseed to all-ones: the first dozen nibbles are 4'hF
    rst = 1'b1;
    q.delete();
    prev_model = '0;
    @(negedge clk);
    rst = 1'b0;
    do_round(1, 0, 1'b0, lat, eo);
    chk("fallback_digit", 32'(d1), 32'd5);
    chk("fallback_lat", 32'(lat), 32'd9);

    @(negedge clk);
    eo = predict(step(m), 3, prev_model);
    eo.req = cyc + 1;
    q.push_back(eo);
    max_digits = 2'd3;
    new_round = 1'b1;
    @(negedge clk);
    new_round = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_digits", 32'(tgt), 32'd0);
    chk("rst_flags", 32'({target_valid, busy}), 32'd0);
    chk("rst_lfsr", 32'(dut.lfsr), 32'(SEED));
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    q.delete();
    prev_model = '0;
    @(negedge clk);
    rst = 1'b0;
    do_round(2, 2, 1'b1, lat, eo);
    chk("round_lat", 32'(lat), 32'(eo.lat));

`ifdef TARGET_NO_REPEAT_EN
    last_obs = tgt;
    for (int r = 0; r < 200; r++) begin
      do_round(1, 0, 1'b0, lat, eo);
      if (!eo.exh) begin
        chk("no_repeat", 32'(tgt == last_obs), 32'd0);
      end
      last_obs = tgt;
    end
`else
    last_obs = tgt;
    for (int r = 0; r < 40; r++) begin
      do_round(1, 0, 1'b0, lat, eo);
      chk("round_lat", 32'(lat), 32'(eo.lat));
      last_obs = tgt;
    end
    chk("last_target", 32'(last_obs), 32'(eo.t));
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
